// File: rtl/pdm_modulator.sv
// pdm_modulator
//   PCM-to-PDM delta-sigma modulator with a 2-entry input sample buffer.
//   Samples are pushed by a valid/ready handshake and are moved into the
//   current-sample register on every ce_pcm strobe. On every ce pulse the
//   integrator chain is advanced and the 1-bit output is re-registered.
//
//   Build option: define PDM_ORDER2_EN for a second-order loop (two
//   integrators, output from the sign of the second). When it is undefined,
//   the loop is first-order.
//
//   Parameters
//     W      PCM sample width, two's complement
//     ACC_W  integrator width (must exceed W)
//   Ports
//     clk           system clock, all state on posedge
//     rst           asynchronous active-high reset
//     ce            PDM bit-rate enable pulse
//     ce_pcm        PCM sample-rate strobe
//     pcm_in        signed sample
//     pcm_valid     pcm_in holds a valid sample
//     pcm_ready     buffer can accept a sample this cycle
//     clr_underrun  clears the sticky underrun flag
//     pdm_out       registered 1-bit PDM stream
//     underrun      sticky: a sample strobe found the buffer empty
module pdm_modulator #(
   parameter int W     = 16,
   parameter int ACC_W = W + 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         ce_pcm,
   input  logic [W-1:0] pcm_in,
   input  logic         pcm_valid,
   output logic         pcm_ready,
   input  logic         clr_underrun,
   output logic         pdm_out,
   output logic         underrun
);

   // Arithmetic is done two bits wider than the integrator so that the
   // unsaturated sum can never wrap before it is clamped.
   localparam int XW = ACC_W + 2;
   localparam logic signed [XW-1:0] FB_MAG  = {{(XW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
   localparam logic signed [XW-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [XW-1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};

   function automatic logic signed [ACC_W-1:0] sat(input logic signed [XW-1:0] v);
      logic signed [XW-1:0] c;
      c = v;
      if (v > SAT_MAX) c = SAT_MAX;
      else if (v < SAT_MIN) c = SAT_MIN;
      return c[ACC_W-1:0];
   endfunction

   // sample buffer: e0 is always the head
   logic [1:0]              count_q, count_d;
   logic [W-1:0]            e0_q, e0_d, e1_q, e1_d;
   logic signed [W-1:0]     x_q, x_d;
   logic                    underrun_q, underrun_d;
   logic                    push, pop;

   logic signed [ACC_W-1:0] acc1_q, acc1_d, acc1_new, fin_new;
   logic                    pdm_q, pdm_d;
   logic signed [XW-1:0]    fb;

`ifdef PDM_ORDER2_EN
   logic signed [ACC_W-1:0] acc2_q, acc2_d, acc2_new;
`endif

   assign pcm_ready = (count_q < 2'd2);
   assign pdm_out   = pdm_q;
   assign underrun  = underrun_q;

   assign push = pcm_valid && pcm_ready;
   assign pop  = ce_pcm && (count_q != 2'd0);

   always_comb begin
      count_d = count_q;
      e0_d    = e0_q;
      e1_d    = e1_q;
      x_d     = x_q;
      if (pop) begin
         x_d = e0_q;
         // push can only coincide with a pop at count 1: the new sample
         // replaces the departing head and the occupancy is unchanged
         if (push) begin
            e0_d = pcm_in;
         end else begin
            e0_d    = e1_q;
            count_d = count_q - 2'd1;
         end
      end else if (push) begin
         if (count_q == 2'd0) e0_d = pcm_in;
         else                 e1_d = pcm_in;
         count_d = count_q + 2'd1;
      end
      // a new underrun outranks a same-cycle clear
      underrun_d = (ce_pcm && (count_q == 2'd0)) || (underrun_q && !clr_underrun);
   end

   always_comb begin
      fb       = pdm_q ? FB_MAG : -FB_MAG;
      acc1_new = sat(XW'(acc1_q) + XW'(x_q) - fb);
`ifdef PDM_ORDER2_EN
      acc2_new = sat(XW'(acc2_q) + XW'(acc1_new) - fb);
      fin_new  = acc2_new;
      acc2_d   = ce ? acc2_new : acc2_q;
`else
      fin_new  = acc1_new;
`endif
      acc1_d = ce ? acc1_new : acc1_q;
      pdm_d  = ce ? ~fin_new[ACC_W-1] : pdm_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         e0_q       <= '0;
         e1_q       <= '0;
         x_q        <= '0;
         underrun_q <= 1'b0;
         acc1_q     <= '0;
         pdm_q      <= 1'b0;
`ifdef PDM_ORDER2_EN
         acc2_q     <= '0;
`endif
      end else begin
         count_q    <= count_d;
         e0_q       <= e0_d;
         e1_q       <= e1_d;
         x_q        <= x_d;
         underrun_q <= underrun_d;
         acc1_q     <= acc1_d;
         pdm_q      <= pdm_d;
`ifdef PDM_ORDER2_EN
         acc2_q     <= acc2_d;
`endif
      end
   end

endmodule
